// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM state encoding and oversampling constants.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and word-side signals of the UART receiver.
// o_parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
  parameter int unsigned DBIT = 8
);
  logic            i_rx;
  logic            i_s_tick;
  logic [DBIT-1:0] o_dout;
  logic            o_rx_done;
  logic            o_frame_err;
  logic            o_busy;
`ifdef UART_RX_PARITY_EN
  logic            o_parity_err;
`endif

  modport slave (
    input  i_rx,
    input  i_s_tick,
    output o_dout,
    output o_rx_done,
    output o_frame_err,
`ifdef UART_RX_PARITY_EN
    output o_parity_err,
`endif
    output o_busy
  );

  modport master (
    output i_rx,
    output i_s_tick,
    input  o_dout,
    input  o_rx_done,
    input  o_frame_err,
`ifdef UART_RX_PARITY_EN
    input  o_parity_err,
`endif
    input  o_busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the idle-high serial line; resets to 1.
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic meta_q, sync_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB-first, one-cycle done strobe with error flags.
// Optional parity stage and o_parity_err enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PAR_ODD = 0
`endif
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  uart_rx_if.slave bus
);
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            armed_q, armed_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            busy_q;
  logic            rx_s;
  logic [DBIT:0]   shift_in;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (bus.i_rx),
    .o_q       (rx_s)
  );

  // New bit enters at the MSB so the first (LSB) bit ends up at bit 0.
  assign shift_in = {rx_s, shreg_q};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: if (bus.i_s_tick) begin
        if (s_q == SW'(MID_TICK)) begin
          // Still low at mid-bit: real start; otherwise a glitch.
          if (!rx_s) begin
            state_d = StData;
            s_d     = '0;
            n_d     = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      StData: if (bus.i_s_tick) begin
        if (s_q == SW'(OVERSAMPLE - 1)) begin
          shreg_d = shift_in[DBIT:1];
          s_d     = '0;
          if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            n_d = n_q + NW'(1);
          end
        end else begin
          s_d = s_q + SW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: if (bus.i_s_tick) begin
        if (s_q == SW'(OVERSAMPLE - 1)) begin
          par_d   = rx_s;
          s_d     = '0;
          state_d = StStop;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
`endif
      StStop: if (bus.i_s_tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          dout_d  = shreg_q;
          ferr_d  = ~rx_s;
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef UART_RX_PARITY_EN
          perr_d  = (^{shreg_q, par_q}) ^ 1'(PAR_ODD);
`endif
          // Break/framing error: wait for the line to return high before re-arming.
          if (!rx_s) armed_d = 1'b0;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= (state_d != StIdle);
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.o_dout      = dout_q;
  assign bus.o_rx_done   = done_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.o_parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: DBIT=8, SB_TICK=16, tick every 4 clocks, 64 clocks per bit.
module tb_uart_rx;
  localparam int unsigned BitClks = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] tick_cnt = 2'd0;
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         base;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt     <= tick_cnt + 2'd1;
    bus.i_s_tick <= (tick_cnt == 2'd3);
  end

  // Count high cycles of the done strobe; a one-cycle pulse adds exactly one.
  always @(negedge clk) if (bus.o_rx_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    bus.i_rx = v;
    wait_clks(BitClks);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input logic has_par, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(par_bit);
    send_bit(stop_bit);
    bus.i_rx = 1'b1;
  endtask

  initial begin
    bus.i_rx     = 1'b1;
    bus.i_s_tick = 1'b0;
    wait_clks(5);
    check("reset_dout", 32'(bus.o_dout), 32'h00);
    check("reset_done", 32'(bus.o_rx_done), 32'h0);
    check("reset_ferr", 32'(bus.o_frame_err), 32'h0);
    check("reset_busy", 32'(bus.o_busy), 32'h0);
    rst_n = 1'b1;
    wait_clks(BitClks);

    // Clean frame
    base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check("a5_done_cnt", 32'(done_cnt - base), 32'd1);
    check("a5_dout", 32'(bus.o_dout), 32'hA5);
    check("a5_ferr", 32'(bus.o_frame_err), 32'h0);
    wait_clks(4);
    check("a5_busy_after", 32'(bus.o_busy), 32'h0);

    // Start glitch: low for 3 ticks only
    base = done_cnt;
    bus.i_rx = 1'b0;
    wait_clks(12);
    bus.i_rx = 1'b1;
    wait_clks(2 * BitClks);
    check("glitch_no_done", 32'(done_cnt - base), 32'd0);
    check("glitch_busy", 32'(bus.o_busy), 32'h0);
    check("glitch_dout", 32'(bus.o_dout), 32'hA5);

    // Framing error with line held low, then recovery
    base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    bus.i_rx = 1'b0;
    check("ferr_done_cnt", 32'(done_cnt - base), 32'd1);
    check("ferr_dout", 32'(bus.o_dout), 32'h3C);
    check("ferr_flag", 32'(bus.o_frame_err), 32'h1);
    wait_clks(3 * BitClks);
    check("ferr_not_rearmed_cnt", 32'(done_cnt - base), 32'd1);
    check("ferr_not_rearmed_busy", 32'(bus.o_busy), 32'h0);
    bus.i_rx = 1'b1;
    wait_clks(BitClks);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    check("recover_done_cnt", 32'(done_cnt - base), 32'd2);
    check("recover_dout", 32'(bus.o_dout), 32'h01);
    check("recover_ferr", 32'(bus.o_frame_err), 32'h0);
    wait_clks(BitClks);

    // Back-to-back frames, no idle gap
    base = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    check("b2b_first_dout", 32'(bus.o_dout), 32'h00);
    check("b2b_first_cnt", 32'(done_cnt - base), 32'd1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    check("b2b_second_dout", 32'(bus.o_dout), 32'hFF);
    check("b2b_second_cnt", 32'(done_cnt - base), 32'd2);
    wait_clks(BitClks);

    // Reset during bit 4 of 0x55
    base = done_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    bus.i_rx = 1'b1;
    wait_clks(BitClks / 2);
    check("rst_mid_busy", 32'(bus.o_busy), 32'h1);
    rst_n = 1'b0;
    wait_clks(3);
    check("rst_mid_dout", 32'(bus.o_dout), 32'h00);
    check("rst_mid_busy_low", 32'(bus.o_busy), 32'h0);
    check("rst_mid_ferr", 32'(bus.o_frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clks(2 * BitClks);
    check("rst_mid_no_done", 32'(done_cnt - base), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    check("post_rst_cnt", 32'(done_cnt - base), 32'd1);
    check("post_rst_dout", 32'(bus.o_dout), 32'h81);
    check("post_rst_ferr", 32'(bus.o_frame_err), 32'h0);
    wait_clks(BitClks);

`ifdef UART_RX_PARITY_EN
    base = done_cnt;
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    check("par_good_dout", 32'(bus.o_dout), 32'h03);
    check("par_good_err", 32'(bus.o_parity_err), 32'h0);
    wait_clks(BitClks);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    check("par_bad_err", 32'(bus.o_parity_err), 32'h1);
    check("par_cnt", 32'(done_cnt - base), 32'd2);
    wait_clks(BitClks);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
